// File: rtl/rotator_pipelined_pkg.sv
// Shared helpers and encodings for the pipelined barrel rotator.
// Left rotation is enabled by ROTATOR_PIPELINED_BIDIRECTIONAL_EN.
package rotator_pipelined_pkg;

  localparam logic ROTATE_RIGHT = 1'b0;
  localparam logic ROTATE_LEFT  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int calc_amount_width(input int w);
    return (clog2(w) < 1) ? 1 : clog2(w);
  endfunction

  function automatic int calc_latency(input int w, input int spr);
    return (calc_amount_width(w) + spr - 1) / spr;
  endfunction

endpackage

// File: rtl/rotator_pipelined_slice.sv
// One register slice: a contiguous range of barrel stages plus a
// valid/ready skid-free pipeline register.
module rotator_pipelined_slice
  import rotator_pipelined_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int AMOUNT_WIDTH = 3,
  parameter int FIRST_STAGE  = 0,
  parameter int STAGE_COUNT  = 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [AMOUNT_WIDTH-1:0] in_amount,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [AMOUNT_WIDTH-1:0] out_amount
);

  localparam int EXT = AMOUNT_WIDTH + FIRST_STAGE + STAGE_COUNT;
  localparam int LAST = FIRST_STAGE + STAGE_COUNT;

  function automatic logic [WIDTH-1:0] rotr(
    input logic [WIDTH-1:0] d,
    input int               s
  );
    logic [2*WIDTH-1:0] dd;
    dd = {d, d} >> s;
    return dd[WIDTH-1:0];
  endfunction

  logic [EXT-1:0]   amount_ext;
  logic [WIDTH-1:0] rotated;

  // Stages past the amount width see zero bits and pass data through.
  always_comb begin
    amount_ext = EXT'(in_amount);
    rotated    = in_data;
    for (int k = 0; k < EXT; k++) begin
      if (k >= FIRST_STAGE && k < LAST && amount_ext[k])
        rotated = rotr(rotated, (1 << k) % WIDTH);
    end
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_amount <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data   <= rotated;
        out_amount <= in_amount;
      end
    end
  end

endmodule

// File: rtl/rotator_pipelined.sv
// Streaming barrel rotator: normalise amount, then LATENCY slices.
// Define ROTATOR_PIPELINED_BIDIRECTIONAL_EN for the in_direction port.
module rotator_pipelined
  import rotator_pipelined_pkg::*;
#(
  parameter int WIDTH               = 8,
  parameter int STAGES_PER_REGISTER = 1,
  localparam int AMOUNT_WIDTH = calc_amount_width(WIDTH),
  localparam int LATENCY      = calc_latency(WIDTH, STAGES_PER_REGISTER)
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [AMOUNT_WIDTH-1:0] in_amount,
`ifdef ROTATOR_PIPELINED_BIDIRECTIONAL_EN
  input  logic                    in_direction,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [AMOUNT_WIDTH-1:0] amount_norm;

  always_comb begin
    amount_norm = AMOUNT_WIDTH'(int'(in_amount) % WIDTH);
`ifdef ROTATOR_PIPELINED_BIDIRECTIONAL_EN
    if (in_direction == ROTATE_LEFT)
      amount_norm = AMOUNT_WIDTH'((WIDTH - int'(amount_norm)) % WIDTH);
`endif
  end

  logic [LATENCY:0]                   valid;
  logic [LATENCY:0]                   ready;
  logic [LATENCY:0][WIDTH-1:0]        data;
  logic [LATENCY:0][AMOUNT_WIDTH-1:0] amount;

  assign valid[0]       = in_valid;
  assign data[0]        = in_data;
  assign amount[0]      = amount_norm;
  assign ready[LATENCY] = out_ready;

  for (genvar i = 0; i < LATENCY; i++) begin : g_slice
    rotator_pipelined_slice #(
      .WIDTH       (WIDTH),
      .AMOUNT_WIDTH(AMOUNT_WIDTH),
      .FIRST_STAGE (i * STAGES_PER_REGISTER),
      .STAGE_COUNT (STAGES_PER_REGISTER)
    ) u_slice (
      .clock     (clock),
      .resetn    (resetn),
      .in_valid  (valid[i]),
      .in_ready  (ready[i]),
      .in_data   (data[i]),
      .in_amount (amount[i]),
      .out_valid (valid[i+1]),
      .out_ready (ready[i+1]),
      .out_data  (data[i+1]),
      .out_amount(amount[i+1])
    );
  end

  // The leftover amount after the last stage carries no information.
  logic unused_amount;
  assign unused_amount = ^amount[LATENCY];

  assign in_ready  = resetn && ready[0];
  assign out_valid = valid[LATENCY];
  assign out_data  = data[LATENCY];

endmodule

// File: tb/tb_rotator_pipelined.sv
// Directed checks of rotator_pipelined at WIDTH 8, 6 and 16.
// Bidirectional steps run when ROTATOR_PIPELINED_BIDIRECTIONAL_EN is set.
module tb_rotator_pipelined;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] d8, od8;
  logic [2:0] a8;
  logic       dir8, v8, ir8, ov8, r8;

  logic [5:0] d6, od6;
  logic [2:0] a6;
  logic       dir6, v6, ir6, ov6, r6;

  logic [15:0] d16, od16;
  logic [3:0]  a16;
  logic        dir16, v16, ir16, ov16, r16;

  rotator_pipelined #(.WIDTH(8), .STAGES_PER_REGISTER(1)) dut (
    .clock       (clk),
    .resetn      (resetn),
    .in_data     (d8),
    .in_amount   (a8),
`ifdef ROTATOR_PIPELINED_BIDIRECTIONAL_EN
    .in_direction(dir8),
`endif
    .in_valid    (v8),
    .in_ready    (ir8),
    .out_data    (od8),
    .out_valid   (ov8),
    .out_ready   (r8)
  );

  rotator_pipelined #(.WIDTH(6), .STAGES_PER_REGISTER(1)) dut6 (
    .clock       (clk),
    .resetn      (resetn),
    .in_data     (d6),
    .in_amount   (a6),
`ifdef ROTATOR_PIPELINED_BIDIRECTIONAL_EN
    .in_direction(dir6),
`endif
    .in_valid    (v6),
    .in_ready    (ir6),
    .out_data    (od6),
    .out_valid   (ov6),
    .out_ready   (r6)
  );

  rotator_pipelined #(.WIDTH(16), .STAGES_PER_REGISTER(2)) dut16 (
    .clock       (clk),
    .resetn      (resetn),
    .in_data     (d16),
    .in_amount   (a16),
`ifdef ROTATOR_PIPELINED_BIDIRECTIONAL_EN
    .in_direction(dir16),
`endif
    .in_valid    (v16),
    .in_ready    (ir16),
    .out_data    (od16),
    .out_valid   (ov16),
    .out_ready   (r16)
  );

  logic [7:0]  exp81 [8] = '{8'h81, 8'hC0, 8'h60, 8'h30,
                             8'h18, 8'h0C, 8'h06, 8'h03};
  logic [2:0]  amt6  [3] = '{3'd7, 3'd6, 3'd5};
  logic [5:0]  exp6  [3] = '{6'b100001, 6'b000011, 6'b000110};
  logic [7:0]  expbp [4] = '{8'h80, 8'h40, 8'h20, 8'h10};
  logic [15:0] dat16 [6] = '{16'h1234, 16'h8001, 16'hABCD,
                             16'h0001, 16'hF000, 16'h1234};
  logic [3:0]  amt16 [6] = '{4'd4, 4'd1, 4'd8, 4'd15, 4'd12, 4'd0};
  logic [15:0] exp16 [6] = '{16'h4123, 16'hC000, 16'hCDAB,
                             16'h0002, 16'h000F, 16'h1234};

  int got;
  int sent;
  int stale;
  int idx;

  initial begin
    d8 = '0; a8 = '0; dir8 = 1'b0; v8 = 1'b0; r8 = 1'b1;
    d6 = '0; a6 = '0; dir6 = 1'b0; v6 = 1'b0; r6 = 1'b1;
    d16 = '0; a16 = '0; dir16 = 1'b0; v16 = 1'b0; r16 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov8, 1'b0);
    chk("rst_out_data", od8, 8'h00);
    chk("rst_in_ready", ir8, 1'b0);
    chk("rst_in_ready16", ir16, 1'b0);
    resetn = 1'b1;
    #1;
    chk("rel_in_ready", ir8, 1'b1);

    v8 = 1'b1; d8 = 8'h81; a8 = 3'd0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c < 8) chk("t1_in_ready", ir8, 1'b1);
      @(posedge clk);
      #1;
      if (c >= 2 && c < 10) begin
        chk("t1_out_valid", ov8, 1'b1);
        chk("t1_out_data", od8, exp81[c-2]);
      end else begin
        chk("t1_idle", ov8, 1'b0);
      end
      if (c + 1 < 8) a8 = 3'(c + 1);
      else v8 = 1'b0;
    end

    v6 = 1'b1; d6 = 6'b000011; a6 = amt6[0];
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (c >= 2) begin
        chk("w6_out_valid", ov6, 1'b1);
        chk("w6_out_data", od6, exp6[c-2]);
      end
      if (c + 1 < 3) a6 = amt6[c+1];
      else v6 = 1'b0;
    end

    r8 = 1'b0; v8 = 1'b1; d8 = 8'h01; a8 = 3'd1;
    @(posedge clk); #1; a8 = 3'd2;
    @(posedge clk); #1; a8 = 3'd3;
    @(posedge clk); #1; a8 = 3'd4;
    for (int c = 0; c < 3; c++) begin
      chk("bp_full_in_ready", ir8, 1'b0);
      chk("bp_full_out_valid", ov8, 1'b1);
      chk("bp_stable_data", od8, 8'h80);
      @(posedge clk);
      #1;
    end
    r8 = 1'b1;
    #1;
    chk("bp_full_release", ir8, 1'b1);
    got = 0;
    sent = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      r8 = (c % 2) == 0;
      v8 = (sent == 0);
      @(negedge clk);
      if (v8 && ir8) sent++;
      if (ov8 && r8) begin
        chk("bp_order", od8, expbp[got]);
        got++;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_count", got, 4);
    v8 = 1'b0; r8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_no_dup", ov8, 1'b0);

`ifdef ROTATOR_PIPELINED_BIDIRECTIONAL_EN
    v8 = 1'b1; d8 = 8'h01; a8 = 3'd3; dir8 = 1'b1;
    @(posedge clk); #1; dir8 = 1'b0;
    @(posedge clk); #1; dir8 = 1'b1; a8 = 3'd5;
    @(posedge clk); #1; v8 = 1'b0;
    chk("bd_left3", od8, 8'h08);
    @(posedge clk); #1;
    chk("bd_right3", od8, 8'h20);
    @(posedge clk); #1;
    chk("bd_left5", od8, 8'h08 << 2);
    dir8 = 1'b0;
    @(posedge clk); #1;
`endif

    r8 = 1'b0; v8 = 1'b1; d8 = 8'h01; a8 = 3'd1;
    repeat (3) begin @(posedge clk); #1; end
    v8 = 1'b0;
    chk("mr_full", ov8, 1'b1);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("mr_out_valid", ov8, 1'b0);
    chk("mr_out_data", od8, 8'h00);
    resetn = 1'b1;
    r8 = 1'b1;
    #1;
    chk("mr_in_ready", ir8, 1'b1);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ov8) stale++;
      @(posedge clk); #1;
    end
    chk("mr_stale", stale, 0);

    v16 = 1'b1; d16 = dat16[0]; a16 = amt16[0]; r16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    chk("w16_lat_early", ov16, 1'b0);
    @(posedge clk); #1;
    chk("w16_lat_valid", ov16, 1'b1);
    chk("w16_lat_data", od16, exp16[0]);
    @(posedge clk); #1;

    got = 0;
    sent = 0;
    for (int c = 0; c < 300 && got < 6; c++) begin
      idx = (sent < 6) ? sent : 0;
      v16 = (sent < 6) && ($urandom_range(0, 3) != 0);
      d16 = dat16[idx];
      a16 = amt16[idx];
      r16 = $urandom_range(0, 2) != 0;
      @(negedge clk);
      if (v16 && ir16) sent++;
      if (ov16 && r16) begin
        chk("w16_stream", od16, exp16[got]);
        got++;
      end
      @(posedge clk);
      #1;
    end
    chk("w16_count", got, 6);
    chk("w16_sent", sent, 6);
    v16 = 1'b0; r16 = 1'b1;
    @(posedge clk); #1;
    chk("w16_drained", ov16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotator_pipelined.md
# rotator_pipelined

Runtime-controlled barrel rotator with a registered, back-pressurable pipeline. Each transaction carries its own data word and rotation amount. It is decomposed into log2 barrel stages, grouped into register slices, and emitted in order on a valid/ready output. It is the streaming successor to the fixed-amount combinational rotator, for datapaths where the amount changes per beat and timing needs register slicing.

## Interface
- WIDTH, 8, data width in bits (≥1)
- STAGES_PER_REGISTER, 1, barrel stages combined per register slice (≥1)
- Derived: AMOUNT_WIDTH = max(1, ceil(log2(WIDTH))); LATENCY = ceil(AMOUNT_WIDTH / STAGES_PER_REGISTER)
- clock  input  1  system clock, all logic on rising edge
- resetn  input  1  synchronous, active-low reset
- in_data  input  WIDTH  word to rotate
- in_amount  input  AMOUNT_WIDTH  rotation amount, unsigned
- in_direction  input  1  0 = right, 1 = left (only with bidirectional macro)
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts beat this cycle
- out_data  output  WIDTH  rotated word
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat

## Operation
- Right rotation by n: out_data[i] = in_data[(i+n) mod WIDTH].
- Amount normalisation at input, combinational before slice 0: n = in_amount mod WIDTH; values ≥ WIDTH wrap (e.g. WIDTH=6, amount 7 → 1). Left rotation by m converts to right by (WIDTH − m mod WIDTH) mod WIDTH.
- Barrel stage k rotates right by 2^k when bit k of the normalised amount is set. Stages run in ascending k. Remaining amount bits travel with the data through each slice.
- Each slice holds valid, data, and remaining amount. Slice i ready = !valid_i || ready_{i+1}; ready_LATENCY = out_ready. in_ready = ready_0. Transfer occurs on valid && ready at every boundary.
- Beats are never dropped, duplicated or reordered. Throughput is 1 beat/cycle when out_ready is held high.
- WIDTH=1: the amount is always 0, out_data = in_data, and LATENCY = 1.

## Timing
- Reset: while resetn=0, all slice valids → 0, data/amount registers → 0, out_valid=0, out_data=0, in_ready=0. in_ready = 1 from the first cycle after release.
- Latency: a beat accepted at edge t appears with out_valid=1 in cycle t+LATENCY−1 following that edge, i.e. LATENCY registers, no extra bubbles.
- out_data is stable while out_valid=1 and out_ready=0.
- Full pipeline: if all LATENCY slices are valid and out_ready=0, then in_ready=0. If out_ready=1 in that state, then in_ready=1, with a simultaneous emit and accept.
- in_ready depends combinationally on out_ready; there is no combinational path from in_data to out_data.
- Reset mid-operation discards all in-flight beats. No output is produced for them.

## Configuration
- ROTATOR_PIPELINED_BIDIRECTIONAL_EN defined: the in_direction port exists and left rotation is supported as above.
- Undefined: the in_direction port is absent, the rotation is always right, and the left-conversion logic is not synthesised.

## Structure
- Package rotator_pipelined_pkg: clog2 helper function, AMOUNT_WIDTH/LATENCY computation functions, and direction encoding constants (ROTATE_RIGHT=0, ROTATE_LEFT=1).
- Sub-module rotator_pipelined_slice: one register slice with handshake. It applies a contiguous range of barrel stages (parameters FIRST_STAGE, STAGE_COUNT, WIDTH) and registers data, remaining amount and valid. The top instantiates LATENCY slices in a generate loop plus the input normalisation logic.

## Test plan
- WIDTH=8, STAGES_PER_REGISTER=1, out_ready=1, in_data=0x81, amounts 0..7 back-to-back → outputs 0x81, 0xC0, 0x60, 0x30, 0x18, 0x0C, 0x06, 0x03, each 3 cycles after acceptance, one per cycle.
- WIDTH=6, amount 7 on 0b000011 → 0b100001 (same as amount 1); amount 6 → unchanged.
- Back-pressure: fill with 0x01 rotated by 1..LATENCY, hold out_ready=0 → in_ready=0 once full and out_data stable. Then toggle out_ready → every beat is emitted exactly once, in order.
- Bidirectional macro on, WIDTH=8: in_data=0x01, direction=1, amount 3 → 0x08; direction=0, amount 3 → 0x20.
- Assert resetn=0 for one cycle with the pipeline full → out_valid=0 the next cycle, no stale beats emitted, in_ready=1 after release.
- STAGES_PER_REGISTER=2, WIDTH=16: LATENCY=2. Random data/amounts compared against a reference model; random valid/ready; no loss or reordering.
